// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, flag bit positions.
// Optional divider is enabled by defining ALU_SEQ_DIV_EN.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_MUL = 3'b100,
      OP_MOV = 3'b101,
      OP_XOR = 3'b110,
      OP_DIV = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_DONE = 2'd2
   } alu_state_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_iter.sv
// One-bit-per-cycle datapath for unsigned shift-add MUL and, when ALU_SEQ_DIV_EN
// is defined, unsigned restoring DIV. {hi,lo} holds product or {remainder,quotient}.
module alu_seq_iter #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
`ifdef ALU_SEQ_DIV_EN
   input  logic           div,
`endif
   input  logic           start,
   input  logic           step,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           last,
   output logic [2*N-1:0] nxt
);

   localparam int CW = $clog2(N);

   logic [CW-1:0] cnt;
   logic [N-1:0]  hi, lo, b_q;
   logic [N:0]    acc;
`ifdef ALU_SEQ_DIV_EN
   logic [N:0]    r2;
   logic [N-1:0]  rem_sub;
`endif

   assign last = (cnt == CW'(N-1));

   always_comb begin
      acc = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(N+1){1'b0}});
      nxt = {acc, lo[N-1:1]};
`ifdef ALU_SEQ_DIV_EN
      r2      = {hi, lo[N-1]};
      // true difference is below 2^N whenever it is kept, so modulo-2^N is exact
      rem_sub = r2[N-1:0] - b_q;
      if (div) begin
         if (r2 >= {1'b0, b_q}) nxt = {rem_sub, lo[N-2:0], 1'b1};
         else                   nxt = {r2[N-1:0], lo[N-2:0], 1'b0};
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         hi  <= '0;
         lo  <= '0;
         b_q <= '0;
      end else if (start) begin
         cnt <= '0;
         hi  <= '0;
         lo  <= a;
         b_q <= b;
      end else if (step) begin
         hi  <= nxt[2*N-1:N];
         lo  <= nxt[N-1:0];
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle logic/arith ops, N-cycle MUL,
// and N-cycle DIV when ALU_SEQ_DIV_EN is defined (otherwise opcode 111 is reserved).
module alu_seq #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic [2:0]     alu_sel,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] result,
   output logic [3:0]     flags,
   output logic           busy
);
   import alu_seq_pkg::*;

   alu_state_e     state, state_nxt;
   alu_op_e        op;
   logic           accept, iter_op, iter_last;
   logic [2*N-1:0] sc_res, iter_nxt;
   logic [3:0]     sc_flags, iter_flags;
   logic [N:0]     sum, diff;
`ifdef ALU_SEQ_DIV_EN
   logic           div_q;
`endif

   assign op        = alu_op_e'(alu_sel);
   assign in_ready  = rst_n && ((state == S_IDLE) || (state == S_DONE && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_ITER);

`ifdef ALU_SEQ_DIV_EN
   // divide-by-zero is resolved in the single-cycle path
   assign iter_op = (op == OP_MUL) || (op == OP_DIV && b != '0);
`else
   assign iter_op = (op == OP_MUL);
`endif

   always_comb begin
      sum      = {1'b0, a} + {1'b0, b};
      diff     = {1'b0, a} - {1'b0, b};
      sc_res   = '0;
      sc_flags = '0;
      case (op)
         OP_ADD: begin
            sc_res[N-1:0]    = sum[N-1:0];
            sc_flags[FLAG_C] = sum[N];
            sc_flags[FLAG_V] = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
         end
         OP_SUB: begin
            sc_res[N-1:0]    = diff[N-1:0];
            sc_flags[FLAG_C] = ~diff[N];
            sc_flags[FLAG_V] = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
         end
         OP_AND: sc_res[N-1:0] = a & b;
         OP_OR:  sc_res[N-1:0] = a | b;
         OP_XOR: sc_res[N-1:0] = a ^ b;
         OP_MOV: sc_res[N-1:0] = b;
         OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
            sc_res = {a, {N{1'b1}}};
`endif
            sc_flags[FLAG_V] = 1'b1;
         end
         default: ;
      endcase
      sc_flags[FLAG_N] = sc_res[N-1];
      sc_flags[FLAG_Z] = (sc_res[N-1:0] == '0);
   end

   always_comb begin
      iter_flags         = '0;
      iter_flags[FLAG_N] = iter_nxt[2*N-1];
      iter_flags[FLAG_Z] = (iter_nxt == '0);
`ifdef ALU_SEQ_DIV_EN
      if (div_q) begin
         iter_flags[FLAG_N] = iter_nxt[N-1];
         iter_flags[FLAG_Z] = (iter_nxt[N-1:0] == '0);
      end
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept)                            state_nxt = iter_op ? S_ITER : S_DONE;
            else if (state == S_DONE && out_ready) state_nxt = S_IDLE;
         end
         S_ITER:  if (iter_last) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         result <= '0;
         flags  <= '0;
      end else begin
         state <= state_nxt;
         if (accept && !iter_op) begin
            result <= sc_res;
            flags  <= sc_flags;
         end else if (state == S_ITER && iter_last) begin
            result <= iter_nxt;
            flags  <= iter_flags;
         end
      end
   end

`ifdef ALU_SEQ_DIV_EN
   always_ff @(posedge clk) begin
      if (!rst_n)      div_q <= 1'b0;
      else if (accept) div_q <= (op == OP_DIV);
   end
`endif

   alu_seq_iter #(.N(N)) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef ALU_SEQ_DIV_EN
      .div   (div_q),
`endif
      .start (accept && iter_op),
      .step  (busy),
      .a     (a),
      .b     (b),
      .last  (iter_last),
      .nxt   (iter_nxt)
   );

endmodule
